// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - shared op codes, state encodings and widths for the ALU sequencer
package alu_seq_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CNT_W-1:0] MUL_LAST = 5'd31;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_XOR  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MULT = 3'b011,
        OP_SLT  = 3'b100,
        OP_NOR  = 3'b101,
        OP_AND  = 3'b110,
        OP_OR   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - request, ALU and result signals of the sequencer
interface alu_seq_ctrl_if;
    import alu_seq_ctrl_pkg::*;

    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cout;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;

    modport slave (
        input  start, op, a, b, alu_res, alu_cout,
        output alu_op, alu_a, alu_b, busy, done, res_hi, res_lo
    );

    modport master (
        output start, op, a, b, alu_res, alu_cout,
        input  alu_op, alu_a, alu_b, busy, done, res_hi, res_lo
    );

endinterface

// File: rtl/mul_shift_reg.sv
// rtl/mul_shift_reg.sv - 64-bit {hi,lo} load/shift register with 5-bit step counter
module mul_shift_reg
    import alu_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              shift,
    input  logic [DATA_W:0]   shift_in,
    output logic [DATA_W-1:0] hi,
    output logic              lo_lsb,
    output logic [DATA_W-1:0] shift_hi,
    output logic [DATA_W-1:0] shift_lo,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // shift_in is {carry, sum}; its lsb falls into the top of lo
    assign shift_hi = shift_in[DATA_W:1];
    assign shift_lo = {shift_in[0], lo_q[DATA_W-1:1]};

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        count_d = count_q;
        if (load) begin
            hi_d    = '0;
            lo_d    = load_val;
            count_d = '0;
        end else if (shift) begin
            hi_d    = shift_hi;
            lo_d    = shift_lo;
            count_d = count_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_d;
        end
    end

    assign hi     = hi_q;
    assign lo_lsb = lo_q[0];
    assign count  = count_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequences single-cycle ops and 32-step shift-add multiply onto an external ALU
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    alu_seq_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_hi_q, res_hi_d;
    logic [DATA_W-1:0] res_lo_q, res_lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              mul_load;
    logic              mul_shift;
    logic [DATA_W-1:0] mul_hi;
    logic              mul_lo_lsb;
    logic [DATA_W-1:0] mul_shift_hi;
    logic [DATA_W-1:0] mul_shift_lo;
    logic [CNT_W-1:0]  mul_count;

    mul_shift_reg u_mul_shift_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (mul_load),
        .load_val (bus.b),
        .shift    (mul_shift),
        .shift_in ({bus.alu_cout, bus.alu_res}),
        .hi       (mul_hi),
        .lo_lsb   (mul_lo_lsb),
        .shift_hi (mul_shift_hi),
        .shift_lo (mul_shift_lo),
        .count    (mul_count)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        mul_load  = 1'b0;
        mul_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d = bus.op;
                    a_d  = bus.a;
                    b_d  = bus.b;
                    if (bus.op == OP_MULT) begin
                        state_d  = ST_MUL;
                        mul_load = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                res_lo_d = bus.alu_res;
                res_hi_d = '0;
                state_d  = ST_DONE;
            end
            ST_MUL: begin
                mul_shift = 1'b1;
                // the final step's shifted value is the product; capture it directly
                if (mul_count == MUL_LAST) begin
                    res_hi_d = mul_shift_hi;
                    res_lo_d = mul_shift_lo;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        bus.alu_op = '0;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        case (state_q)
            ST_ISSUE: begin
                bus.alu_op = op_q;
                bus.alu_a  = a_q;
                bus.alu_b  = b_q;
            end
            ST_MUL: begin
                bus.alu_op = OP_ADD;
                bus.alu_a  = mul_hi;
                bus.alu_b  = mul_lo_lsb ? a_q : '0;
            end
            default: ;
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.res_hi = res_hi_q;
    assign bus.res_lo = res_lo_q;

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: none; the datapath is a fixed 32 bits and alu_op is a fixed 3 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request strobe; sampled only in IDLE.
REQ-005 op  in  3  requested operation: 000 ADD, 001 XOR, 010 SUB, 011 MULT, 100 SLT, 101 NOR, 110 AND, 111 OR.
REQ-006 a, b  in  32 each  operands; sampled with start.
REQ-007 alu_res  in  32  result returned by the combinational 32-bit ALU.
REQ-008 alu_cout  in  1  carry out of ALU bit 31.
REQ-009 alu_op  out  3  operation code driven to the ALU.
REQ-010 alu_a, alu_b  out  32 each  operands driven to the ALU.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse; the result is valid in the same cycle.
REQ-013 res_hi, res_lo  out  32 each  result; non-MULT ops use res_lo only, with res_hi=0.

Function
REQ-014 FSM states shall be IDLE, ISSUE, MUL, DONE; the encoding is free.
REQ-015 In IDLE with start=1, the block shall latch op, a and b.
  - op!=011: next state is ISSUE.
  - op=011: next state is MUL; it shall also load lo=b, hi=0, count=0.
REQ-016 In IDLE with start=0, the block shall hold its state; start in any other state shall be ignored, with no queuing.
REQ-017 ISSUE: the block shall drive alu_op=latched op, alu_a=a, alu_b=b, capture res_lo=alu_res and res_hi=0 at the edge, then go to DONE.
REQ-018 MUL (unsigned shift-add): the block shall drive alu_op=000, alu_a=hi, and alu_b=a if lo[0]=1, else 0.
  - At each edge: {hi,lo} <= {alu_cout, alu_res, lo[31:1]}, and count increments.
REQ-019 MUL shall go to DONE at the edge where count=31, i.e. exactly 32 MUL cycles; count is 5 bits and wraps to 0 without affecting the exit.
REQ-020 DONE: the block shall assert done=1 and present res_hi/res_lo, then return to IDLE at the next edge.
REQ-021 A start present in DONE shall be ignored; a new start is accepted only from IDLE, one cycle later.
REQ-022 Latency from the start-sampling edge to done high: non-MULT 2 cycles; MULT 33 cycles.
REQ-023 res_hi/res_lo shall hold their value after DONE until the next operation's capture.
REQ-024 In IDLE and DONE, alu_op/alu_a/alu_b shall be 0.
REQ-025 SLT and SUB carry/sign interpretation belongs to the ALU; this block shall pass alu_res through unmodified.

Reset
REQ-026 While reset=1, independent of clk: state=IDLE, busy=0, done=0, res_hi=res_lo=0, count=0, latched operands=0, alu_op/alu_a/alu_b=0.
REQ-027 Reset asserted mid-MUL or mid-ISSUE shall abort the operation with no done pulse; after release, the first start shall be served normally.

Structure
REQ-028 The op-code constants (ADD..OR) and the state encodings shall live in a shared package used by alu_seq_ctrl and the ALU control path.
REQ-029 One sub-module is natural: mul_shift_reg, the 64-bit {hi,lo} shift/load register with 5-bit counter; all other logic shall be inline.
REQ-030 The ALU itself shall be instantiated outside this block; this block shall contain no adder.

Verification
REQ-031 ADD a=7, b=5, start 1 cycle -> done 2 cycles later, res_lo=12, res_hi=0, busy high for 2 cycles.
REQ-032 MULT a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 cycles later, res_hi=0xFFFFFFFE, res_lo=0x00000001.
REQ-033 MULT a=3, b=0 -> all 32 MUL cycles drive alu_b=0, result 0/0; start pulsed during MUL is ignored, with no second done.
REQ-034 Reset asserted at MUL cycle 10 -> busy=0 and outputs 0 immediately; no done; a following SUB a=5, b=9 -> res_lo=0xFFFFFFFC.
REQ-035 Back-to-back: start held high continuously, op=AND a=0xF0F0F0F0 b=0xFF00FF00 -> done every 3 cycles, each with res_lo=0xF000F000.
